// File: rtl/dbg_bus_arbiter.sv
// Round-robin arbiter that lets NB_REQ requesters share one core debug port.
// Latency: target strobe 1 cycle after a request is seen in IDLE; ack 1 cycle after tgt_ack_i.
// Backpressure: requesters hold req_stb_i until req_ack_o; a silent target is cut off after TIMEOUT cycles.
module dbg_bus_arbiter #(
    parameter int NB_REQ     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NB_REQ-1:0]                     req_stb_i,
    input  logic [NB_REQ-1:0]                     req_we_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]     req_wdata_i,
    output logic [NB_REQ-1:0]                     req_ack_o,
    output logic                                  req_err_o,
    output logic [DATA_WIDTH-1:0]                 req_rdata_o,
    output logic                                  tgt_stb_o,
    output logic                                  tgt_we_o,
    output logic [ADDR_WIDTH-1:0]                 tgt_addr_o,
    output logic [DATA_WIDTH-1:0]                 tgt_data_o,
    input  logic [DATA_WIDTH-1:0]                 tgt_data_i,
    input  logic                                  tgt_ack_i,
    output logic                                  busy_o
);

    localparam int              IDX_W   = $clog2(NB_REQ);
    localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [NB_REQ-1:0]       req_ack_q, req_ack_d;
    logic                    req_err_q, req_err_d;
    logic [DATA_WIDTH-1:0]   req_rdata_q, req_rdata_d;
    logic                    tgt_stb_q, tgt_stb_d;
    logic                    tgt_we_q, tgt_we_d;
    logic [ADDR_WIDTH-1:0]   tgt_addr_q, tgt_addr_d;
    logic [DATA_WIDTH-1:0]   tgt_data_q, tgt_data_d;
    logic                    busy_q, busy_d;

    logic                    rr_found;
    logic [IDX_W-1:0]        rr_idx;
    logic [IDX_W-1:0]        cand_idx;
    int                      cand;

    // First requester strictly after last_grant, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NB_REQ; i++) begin
            cand     = (int'(last_grant_q) + i) % NB_REQ;
            cand_idx = IDX_W'(cand);
            if (!rr_found && req_stb_i[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        req_ack_d    = '0;
        req_err_d    = req_err_q;
        req_rdata_d  = req_rdata_q;
        tgt_stb_d    = tgt_stb_q;
        tgt_we_d     = tgt_we_q;
        tgt_addr_d   = tgt_addr_q;
        tgt_data_d   = tgt_data_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d    = ACCESS;
                    grant_d    = rr_idx;
                    cnt_d      = '0;
                    tgt_stb_d  = 1'b1;
                    tgt_we_d   = req_we_i[rr_idx];
                    tgt_addr_d = req_addr_i[rr_idx];
                    tgt_data_d = req_wdata_i[rr_idx];
                end
            end
            ACCESS: begin
                if (tgt_ack_i) begin
                    state_d            = RESP;
                    tgt_stb_d          = 1'b0;
                    req_ack_d[grant_q] = 1'b1;
                    req_err_d          = 1'b0;
                    req_rdata_d        = tgt_data_i;
                end else if (cnt_q == TO_LAST) begin
                    state_d            = RESP;
                    tgt_stb_d          = 1'b0;
                    req_ack_d[grant_q] = 1'b1;
                    req_err_d          = 1'b1;
                    req_rdata_d        = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                last_grant_d = grant_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NB_REQ - 1);
            cnt_q        <= '0;
            req_ack_q    <= '0;
            req_err_q    <= 1'b0;
            req_rdata_q  <= '0;
            tgt_stb_q    <= 1'b0;
            tgt_we_q     <= 1'b0;
            tgt_addr_q   <= '0;
            tgt_data_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            req_ack_q    <= req_ack_d;
            req_err_q    <= req_err_d;
            req_rdata_q  <= req_rdata_d;
            tgt_stb_q    <= tgt_stb_d;
            tgt_we_q     <= tgt_we_d;
            tgt_addr_q   <= tgt_addr_d;
            tgt_data_q   <= tgt_data_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ack_o   = req_ack_q;
    assign req_err_o   = req_err_q;
    assign req_rdata_o = req_rdata_q;
    assign tgt_stb_o   = tgt_stb_q;
    assign tgt_we_o    = tgt_we_q;
    assign tgt_addr_o  = tgt_addr_q;
    assign tgt_data_o  = tgt_data_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/dbg_bus_arbiter.md
DBG_BUS_ARBITER -- requirements
Module: dbg_bus_arbiter

Interface
REQ-001 Parameter NB_REQ, default 2: number of requesters sharing one core debug bus (range 2..8).
REQ-002 Parameter ADDR_WIDTH, default 16: debug-bus address width.
REQ-003 Parameter DATA_WIDTH, default 32: debug-bus data width.
REQ-004 Parameter TIMEOUT, default 255: maximum cycles tgt_stb_o waits for tgt_ack_i (range 1..65535).
REQ-005 The block has one clock; reset is synchronous and active-high.
REQ-006 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 req_stb_i  input  NB_REQ  per-requester access strobe, held until its req_ack_o.
REQ-009 req_we_i  input  NB_REQ  per-requester write enable (1 = write, 0 = read).
REQ-010 req_addr_i  input  NB_REQ x ADDR_WIDTH  per-requester address.
REQ-011 req_wdata_i  input  NB_REQ x DATA_WIDTH  per-requester write data.
REQ-012 req_ack_o  output  NB_REQ  one-cycle completion pulse to the granted requester.
REQ-013 req_err_o  output  1  qualifies req_ack_o: 1 = timeout, access not acknowledged by target.
REQ-014 req_rdata_o  output  DATA_WIDTH  read data, valid while any req_ack_o bit is 1.
REQ-015 tgt_stb_o / tgt_we_o  output  1 / 1  strobe and write enable to the core debug port.
REQ-016 tgt_addr_o / tgt_data_o  output  ADDR_WIDTH / DATA_WIDTH  address and write data to the core.
REQ-017 tgt_data_i / tgt_ack_i  input  DATA_WIDTH / 1  read data and acknowledge from the core.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-020 IDLE: if any req_stb_i bit is 1, select winner by round-robin, searching from (last_grant+1) mod NB_REQ upward with wrap; latch index, we, addr, wdata; next state ACCESS; otherwise stay.
REQ-021 ACCESS: tgt_stb_o=1 with latched we/addr/data, held constant for the whole state.
REQ-022 ACCESS with tgt_ack_i=1: capture tgt_data_i into req_rdata_o, req_err_o=0, next RESP; tgt_stb_o drops in the following cycle.
REQ-023 Timeout counter clears on entry to ACCESS and increments each ACCESS cycle without ack; when it reaches TIMEOUT-1 with no ack, next RESP with req_err_o=1 and req_rdata_o=0.
REQ-024 Ack in the same cycle the counter reaches TIMEOUT-1 is a normal completion (err=0).
REQ-025 RESP lasts exactly one cycle: req_ack_o[grant]=1, all other bits 0; last_grant updated to grant; next IDLE.
REQ-026 Latency: req_stb_i sampled high in IDLE at cycle N -> tgt_stb_o high from N+1; tgt_ack_i at cycle M -> req_ack_o at M+1; minimum 3 cycles per transaction.
REQ-027 Requests arriving while busy are not lost; they are arbitrated at the next IDLE.
REQ-028 Requester dropping req_stb_i during ACCESS does not abort; access completes and req_ack_o still pulses.
REQ-029 tgt_ack_i outside ACCESS is ignored.
REQ-030 A single continuous requester is re-granted after each IDLE; any other pending requester is served before it is granted twice in a row.

Reset
REQ-031 rst_i=1 forces IDLE, last_grant=NB_REQ-1 (requester 0 wins first), timeout counter=0.
REQ-032 Reset values: req_ack_o=0, req_err_o=0, req_rdata_o=0, tgt_stb_o=0, tgt_we_o=0, tgt_addr_o=0, tgt_data_o=0, busy_o=0.
REQ-033 Reset asserted mid-ACCESS drops tgt_stb_o the next cycle, issues no req_ack_o, and discards the access.

Verification
REQ-034 Single read: req 0 addr 0x0010, target acks 2 cycles later with 0xDEADBEEF -> one req_ack_o[0] pulse, req_rdata_o=0xDEADBEEF, err=0.
REQ-035 Contention: reqs 0 and 1 asserted continuously from reset -> grant order 0,1,0,1; tgt_addr_o matches each winner.
REQ-036 Timeout: TIMEOUT=4, target never acks -> tgt_stb_o high exactly 4 cycles, then req_ack_o pulse with req_err_o=1, rdata=0.
REQ-037 Boundary ack: TIMEOUT=4, ack on 4th ACCESS cycle -> err=0, captured data returned.
REQ-038 Write: req 1 we=1 addr 0x0200 data 0x12345678 -> tgt_we_o=1, tgt_data_o=0x12345678 stable until ack; req_ack_o[1] pulse.
REQ-039 Reset mid-ACCESS -> next cycle tgt_stb_o=0, busy_o=0, no req_ack_o; following request goes to requester 0.
